uart_bus_bridge: RTL and testbench

Host-facing command responder on the UART byte interface. Consumes received bytes (`rx_complete`/`rx_data`), decodes read/write command frames, and performs one 32-bit bus transaction per frame as bus master. It returns the response bytes through the UART transmit handshake (`tx_valid`/`tx_data`/`tx_complete`). It sits between the `uart` block and the system bus and acts as the debug/load path for the host.

---
 rtl/uart_bus_bridge_pkg.sv | 25 ++
 rtl/uart_bus_bridge_if.sv | 29 ++
 rtl/uart_bus_bridge_resp_sender.sv | 64 ++++++
 rtl/uart_bus_bridge.sv | 152 +++++++++++++++
 tb/tb_uart_bus_bridge.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_bus_bridge_pkg.sv
// uart_bridge_pkg: shared types and constants for the UART host bus bridge.
//   state_t    - command FSM states
//   CMD_*      - first byte of a host command frame
//   RSP_*      - single-byte responses
//   is_cmd()   - true when a byte opens a read or write frame
package uart_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_BUS   = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h3F;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WRITE) || (b == CMD_READ);
  endfunction

endpackage

// File: rtl/uart_bus_bridge_if.sv
// uart_bus_bridge_if: byte-level UART handshake plus 32-bit bus master port.
//   rx_complete/rx_data            : received byte strobe (from uart)
//   tx_valid/tx_data/tx_complete   : transmit handshake (to/from uart)
//   bus_req/bus_write/bus_addr/
//   bus_wdata/bus_ack/bus_rdata    : single-transaction bus
// Modports: master = the bridge, slave = uart + bus side.
interface uart_bus_bridge_if;
  logic        rx_complete;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_complete;
  logic        bus_req;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    input  rx_complete, rx_data, tx_complete, bus_ack, bus_rdata,
    output tx_valid, tx_data, bus_req, bus_write, bus_addr, bus_wdata
  );

  modport slave (
    output rx_complete, rx_data, tx_complete, bus_ack, bus_rdata,
    input  tx_valid, tx_data, bus_req, bus_write, bus_addr, bus_wdata
  );
endinterface

// File: rtl/uart_bus_bridge_resp_sender.sv
// uart_resp_sender: sends a 1- or 4-byte response, LSB first, over the
// UART transmit handshake.
//   clock, reset     : system clock, synchronous active-high reset
//   i_start          : load i_word/i_len4 and present the first byte next edge
//   i_word           : response word
//   i_len4           : 1 = four bytes, 0 = one byte (i_word[7:0])
//   i_tx_complete    : uart has taken the current byte (stop bit started)
//   o_tx_valid/o_tx_data : byte offered to the uart
//   o_done           : combinational pulse in the cycle of the last tx_complete
module uart_resp_sender (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_start,
  input  logic [31:0] i_word,
  input  logic        i_len4,
  input  logic        i_tx_complete,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_done
);
  logic        r_busy;
  logic        r_tx_valid;
  logic [7:0]  r_tx_data;
  logic        r_len4;
  logic [1:0]  r_idx;
  logic [31:0] r_word;
  logic        w_sent;
  logic        w_last;

  assign w_sent = r_tx_valid & i_tx_complete;
  assign w_last = r_len4 ? (r_idx == 2'd3) : 1'b1;
  assign o_done = w_sent & w_last;

  assign o_tx_valid = r_tx_valid;
  assign o_tx_data  = r_tx_data;

  // Between bytes tx_valid is low for exactly one cycle: the byte index
  // advances on the tx_complete edge and the next byte is offered on the
  // following edge, still inside the uart's stop bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy     <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
      r_len4     <= 1'b0;
      r_idx      <= 2'd0;
      r_word     <= 32'd0;
    end else if (i_start) begin
      r_busy     <= 1'b1;
      r_word     <= i_word;
      r_len4     <= i_len4;
      r_idx      <= 2'd0;
      r_tx_valid <= 1'b1;
      r_tx_data  <= i_word[7:0];
    end else if (w_sent) begin
      r_tx_valid <= 1'b0;
      if (w_last) r_busy <= 1'b0;
      else        r_idx  <= r_idx + 2'd1;
    end else if (r_busy && !r_tx_valid) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= r_word[{r_idx, 3'b000} +: 8];
    end
  end
endmodule

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: host command responder. Parses read/write frames from
// the uart receive strobe, performs one 32-bit bus access per frame and
// returns the response through uart_resp_sender.
//   TIMEOUT_CYCLES : inter-byte gap limit (only with UART_BRIDGE_TIMEOUT_EN)
//   clock, reset   : system clock, synchronous active-high reset
//   bus_if         : uart_bus_bridge_if.master (uart rx/tx + bus master)
// Optional build macro: UART_BRIDGE_TIMEOUT_EN - abandon a partial frame
// after TIMEOUT_CYCLES idle clocks in ADDR/WDATA (no response, no access).
//
// state    | meaning
// ST_IDLE  | waiting for a command byte
// ST_ADDR  | collecting 4 address bytes, LSB first
// ST_WDATA | collecting 4 write-data bytes, LSB first
// ST_BUS   | bus_req high until bus_ack
// ST_RESP  | sender transmitting the 1- or 4-byte response
module uart_bus_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1200000
) (
  input  logic              clock,
  input  logic              reset,
  uart_bus_bridge_if.master bus_if
);
  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_cnt;
  logic        r_is_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        w_rx;
  logic        w_field_last;
  logic        w_timeout;
  logic        w_start;
  logic        w_len4;
  logic [31:0] w_resp_word;
  logic        w_done;

  assign w_rx         = bus_if.rx_complete;
  assign w_field_last = (r_cnt == 2'd3);

`ifdef UART_BRIDGE_TIMEOUT_EN
  localparam int unsigned GAP_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [GAP_W-1:0] r_gap;

  // Held at zero in IDLE, so entry to ADDR always starts from a clear count.
  always_ff @(posedge clock) begin
    if (reset || w_rx || (r_state == ST_IDLE))
      r_gap <= '0;
    else if ((r_state == ST_ADDR) || (r_state == ST_WDATA))
      r_gap <= r_gap + 1'b1;
  end

  assign w_timeout = ((r_state == ST_ADDR) || (r_state == ST_WDATA)) && !w_rx &&
                     (r_gap == GAP_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:
        if (w_rx) w_state_next = is_cmd(bus_if.rx_data) ? ST_ADDR : ST_RESP;
      ST_ADDR:
        if (w_timeout)                 w_state_next = ST_IDLE;
        else if (w_rx && w_field_last) w_state_next = r_is_write ? ST_WDATA : ST_BUS;
      ST_WDATA:
        if (w_timeout)                 w_state_next = ST_IDLE;
        else if (w_rx && w_field_last) w_state_next = ST_BUS;
      ST_BUS:
        if (bus_if.bus_ack) w_state_next = ST_RESP;
      ST_RESP:
        if (w_done) w_state_next = ST_IDLE;
      default:
        w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_start     = 1'b0;
    w_len4      = 1'b0;
    w_resp_word = {24'd0, RSP_ERR};
    case (r_state)
      ST_IDLE:
        w_start = w_rx && !is_cmd(bus_if.rx_data);
      ST_BUS:
        if (bus_if.bus_ack) begin
          w_start = 1'b1;
          if (r_is_write) begin
            w_resp_word = {24'd0, RSP_ACK};
          end else begin
            w_resp_word = bus_if.bus_rdata;
            w_len4      = 1'b1;
          end
        end
      default: ;
    endcase
  end

  assign bus_if.bus_req   = (r_state == ST_BUS);
  assign bus_if.bus_write = r_is_write;
  assign bus_if.bus_addr  = r_addr;
  assign bus_if.bus_wdata = r_wdata;

  // cnt wraps 3 -> 0 at the end of each field, so it is already zero when
  // WDATA starts collecting.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt      <= 2'd0;
      r_is_write <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE:
          if (w_rx) begin
            r_cnt      <= 2'd0;
            r_is_write <= (bus_if.rx_data == CMD_WRITE);
          end
        ST_ADDR:
          if (w_rx) begin
            r_addr[{r_cnt, 3'b000} +: 8] <= bus_if.rx_data;
            r_cnt <= r_cnt + 2'd1;
          end
        ST_WDATA:
          if (w_rx) begin
            r_wdata[{r_cnt, 3'b000} +: 8] <= bus_if.rx_data;
            r_cnt <= r_cnt + 2'd1;
          end
        default: ;
      endcase
    end
  end

  uart_resp_sender u_sender (
    .clock         (clock),
    .reset         (reset),
    .i_start       (w_start),
    .i_word        (w_resp_word),
    .i_len4        (w_len4),
    .i_tx_complete (bus_if.tx_complete),
    .o_tx_valid    (bus_if.tx_valid),
    .o_tx_data     (bus_if.tx_data),
    .o_done        (w_done)
  );
endmodule

// File: tb/tb_uart_bus_bridge.sv
// Testbench for uart_bus_bridge: directed test-plan frames followed by
// random frames, checked against a frame-level model of the protocol.
module tb_uart_bus_bridge;
  import uart_bridge_pkg::*;

  typedef logic [7:0] bytes_t[$];

  localparam int TX_D = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_rx = 0;

  int          bm_wait = 0;
  logic [31:0] bm_rdata = 32'd0;

  logic        bq_write[$];
  logic [31:0] bq_addr[$];
  logic [31:0] bq_wdata[$];
  int          bq_len[$];
  int          bq_start[$];
  int          bq_ack[$];
  logic [7:0]  tq_data[$];
  int          tq_cyc[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  uart_bus_bridge_if bif ();

  uart_bus_bridge #(.TIMEOUT_CYCLES(100)) dut (
    .clock  (clock),
    .reset  (reset),
    .bus_if (bif)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_q();
    bq_write.delete(); bq_addr.delete(); bq_wdata.delete();
    bq_len.delete(); bq_start.delete(); bq_ack.delete();
    tq_data.delete(); tq_cyc.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bif.rx_data     = b;
    bif.rx_complete = 1'b1;
    last_rx         = cyc;
    tick(1);
    bif.rx_complete = 1'b0;
    bif.rx_data     = 8'($urandom);
    tick(gap);
  endtask

  function automatic bytes_t mk_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d);
    bytes_t f;
    f.push_back(cmd);
    if (cmd == 8'h57 || cmd == 8'h52)
      for (int i = 0; i < 4; i++) f.push_back(a[8*i +: 8]);
    if (cmd == 8'h57)
      for (int i = 0; i < 4; i++) f.push_back(d[8*i +: 8]);
    return f;
  endfunction

  // Bus slave: acks after bm_wait wait cycles, logs each transaction.
  initial begin
    int run;
    run = 0;
    bif.bus_ack = 1'b0;
    bif.bus_rdata = 32'd0;
    forever begin
      @(negedge clock);
      bif.bus_ack = 1'b0;
      if (bif.bus_req === 1'b1) begin
        if (run == 0) bq_start.push_back(cyc);
        run++;
        if (run == bm_wait + 1) begin
          bif.bus_ack   = 1'b1;
          bif.bus_rdata = bm_rdata;
          bq_write.push_back(bif.bus_write);
          bq_addr.push_back(bif.bus_addr);
          bq_wdata.push_back(bif.bus_wdata);
          bq_ack.push_back(cyc);
        end
      end else if (run != 0) begin
        bq_len.push_back(run);
        run = 0;
      end
    end
  end

  // UART transmitter: takes a byte, pulses tx_complete TX_D cycles later.
  initial begin
    int cd;
    cd = -1;
    bif.tx_complete = 1'b0;
    forever begin
      @(negedge clock);
      bif.tx_complete = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bif.tx_complete = 1'b1;
          cd = -1;
        end
      end else if (bif.tx_valid === 1'b1) begin
        tq_data.push_back(bif.tx_data);
        tq_cyc.push_back(cyc);
        cd = TX_D;
      end
    end
  end

  task automatic run_frame(input string name, input bytes_t fr, input int wait_c,
                           input logic [31:0] rdata, input bit junk,
                           input int pause_at, input int pause_len);
    bit          exp_bus;
    logic        exp_write;
    logic [31:0] exp_addr, exp_wdata;
    logic [7:0]  exp_resp[$];
    int          rx_end;
    int          k;

    clear_q();
    bm_wait  = wait_c;
    bm_rdata = rdata;
    exp_bus  = 1'b0;
    exp_write = 1'b0;
    exp_addr = 32'd0;
    exp_wdata = 32'd0;
    if (fr[0] == 8'h57) begin
      exp_bus   = 1'b1;
      exp_write = 1'b1;
      exp_addr  = {fr[4], fr[3], fr[2], fr[1]};
      exp_wdata = {fr[8], fr[7], fr[6], fr[5]};
      exp_resp.push_back(8'h4B);
    end else if (fr[0] == 8'h52) begin
      exp_bus  = 1'b1;
      exp_addr = {fr[4], fr[3], fr[2], fr[1]};
      for (int i = 0; i < 4; i++) exp_resp.push_back(rdata[8*i +: 8]);
    end else begin
      exp_resp.push_back(8'h3F);
    end

    for (int i = 0; i < fr.size(); i++)
      send_byte(fr[i], (i == fr.size() - 1) ? 0 :
                       (i == pause_at) ? pause_len : int'($urandom_range(0, 3)));
    rx_end = last_rx;

    if (junk && exp_bus) begin
      k = 0;
      while (bif.bus_req !== 1'b1 && k < 50) begin tick(1); k++; end
      send_byte(8'h52, 0);
      k = 0;
      while (bif.tx_valid !== 1'b1 && k < 100) begin tick(1); k++; end
      send_byte(8'h57, 0);
    end

    k = 0;
    while (tq_data.size() < exp_resp.size() && k < 400) begin tick(1); k++; end
    tick(TX_D + 4);

    check({name, " bus count"}, bq_ack.size(), exp_bus ? 1 : 0);
    if (exp_bus && bq_ack.size() > 0) begin
      check({name, " bus_write"}, bq_write[0], exp_write);
      check({name, " bus_addr"}, bq_addr[0], exp_addr);
      if (exp_write) check({name, " bus_wdata"}, bq_wdata[0], exp_wdata);
      check({name, " req start"}, bq_start[0], rx_end + 1);
      if (bq_len.size() > 0) check({name, " req cycles"}, bq_len[0], wait_c + 1);
    end
    check({name, " resp count"}, tq_data.size(), exp_resp.size());
    for (int i = 0; i < exp_resp.size() && i < tq_data.size(); i++)
      check({name, " resp byte"}, tq_data[i], exp_resp[i]);
    if (tq_cyc.size() > 0)
      check({name, " first tx"}, tq_cyc[0],
            (exp_bus && bq_ack.size() > 0) ? bq_ack[0] + 1 : rx_end + 1);
    for (int i = 1; i < tq_cyc.size(); i++)
      check({name, " tx spacing"}, tq_cyc[i] - tq_cyc[i-1], TX_D + 2);
    check({name, " idle after"}, dut.r_state, ST_IDLE);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [7:0] b;
    bif.rx_complete = 1'b0;
    bif.rx_data     = 8'h00;
    reset = 1'b1;
    tick(3);
    check("rst tx_valid", bif.tx_valid, 1'b0);
    check("rst tx_data", bif.tx_data, 8'h00);
    check("rst bus_req", bif.bus_req, 1'b0);
    check("rst bus_write", bif.bus_write, 1'b0);
    check("rst bus_addr", bif.bus_addr, 32'd0);
    check("rst bus_wdata", bif.bus_wdata, 32'd0);
    reset = 1'b0;
    tick(2);

    run_frame("write", mk_frame(8'h57, 32'h8000_0010, 32'hDEAD_BEEF), 0, 32'h0, 1'b0, -1, 0);
    run_frame("read", mk_frame(8'h52, 32'h0000_0004, 32'h0), 5, 32'h1234_5678, 1'b0, -1, 0);
    run_frame("bad", mk_frame(8'hA0, 32'h0, 32'h0), 0, 32'h0, 1'b0, -1, 0);
    run_frame("read after bad", mk_frame(8'h52, 32'hCAFE_0100, 32'h0), 1, 32'hA5C3_0F81, 1'b0, -1, 0);
    run_frame("junk read", mk_frame(8'h52, 32'h0000_2000, 32'h0), 4, 32'h0BAD_F00D, 1'b1, -1, 0);
    run_frame("junk write", mk_frame(8'h57, 32'h0000_3000, 32'h1111_2222), 3, 32'h0, 1'b1, -1, 0);

`ifdef UART_BRIDGE_TIMEOUT_EN
    clear_q();
    send_byte(8'h57, 0);
    send_byte(8'h10, 0);
    send_byte(8'h00, 100);
    tick(1);
    check("timeout idle", dut.r_state, ST_IDLE);
    check("timeout no bus", bq_start.size(), 0);
    check("timeout no tx", tq_data.size(), 0);
    run_frame("read after timeout", mk_frame(8'h52, 32'h0000_0040, 32'h0), 2, 32'h7766_5544, 1'b0, -1, 0);
`else
    run_frame("paused write", mk_frame(8'h57, 32'h8000_0010, 32'h0102_0304), 0, 32'h0, 1'b0, 2, 150);
`endif

    // reset while bus_req is high
    clear_q();
    bm_wait = 50;
    send_byte(8'h52, 0);
    for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
    k = 0;
    while (bif.bus_req !== 1'b1 && k < 20) begin tick(1); k++; end
    check("pre-reset bus_req", bif.bus_req, 1'b1);
    reset = 1'b1;
    tick(1);
    check("reset bus_req", bif.bus_req, 1'b0);
    check("reset state bus", dut.r_state, ST_IDLE);
    reset = 1'b0;
    tick(2);

    // reset while tx_valid is high
    send_byte(8'hC4, 0);
    k = 0;
    while (bif.tx_valid !== 1'b1 && k < 20) begin tick(1); k++; end
    check("pre-reset tx_valid", bif.tx_valid, 1'b1);
    reset = 1'b1;
    tick(1);
    check("reset tx_valid", bif.tx_valid, 1'b0);
    check("reset tx_data", bif.tx_data, 8'h00);
    check("reset state resp", dut.r_state, ST_IDLE);
    reset = 1'b0;
    tick(TX_D + 4);

    for (int n = 0; n < 10; n++) begin
      int kind, w;
      kind = $urandom_range(0, 2);
      w    = $urandom_range(0, 6);
      if (kind == 0) b = 8'h57;
      else if (kind == 1) b = 8'h52;
      else begin
        b = 8'($urandom);
        while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
      end
      run_frame("random", mk_frame(b, $urandom, $urandom), w, $urandom,
                (w >= 2) && ($urandom_range(0, 1) == 1), -1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
